fma16_round: RTL and testbench

- Pipelined rounding stage directly downstream of the fma16 addition/normalization stage.
- Consumes the truncated packed sum, the full normalized 34-bit significand and the insignificance flag, then applies the selected IEEE rounding mode.
- Produces the final half-precision result plus overflow/inexact flags (per-op and sticky).
- Two register stages with valid/ready handshake on both sides.

---
 rtl/fma16_round_if.sv | 37 +++
 rtl/fma16_round.sv | 182 ++++++++++++++++++
 tb/tb_fma16_round.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fma16_round_if.sv
// fma16_round_if: handshake and data bundle for the fma16 rounding stage.
//   master : upstream/downstream environment (drives operands, out_ready, flags_clr)
//   slave  : rounding stage (drives in_ready, result, per-op and sticky flags)
//   Signals: in_valid/in_ready, sum[15:0], fullSum[FW-1:0], nSigFlag[1:0],
//            lostsign, roundmode[1:0], out_valid/out_ready, result[15:0],
//            of, nx, flags_clr, sticky_of, sticky_nx
interface fma16_round_if #(
    parameter int FW = 34
);
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   sum;
    logic [FW-1:0] fullSum;
    logic [1:0]    nSigFlag;
    logic          lostsign;
    logic [1:0]    roundmode;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   result;
    logic          of;
    logic          nx;
    logic          flags_clr;
    logic          sticky_of;
    logic          sticky_nx;

    modport master (
        output in_valid, sum, fullSum, nSigFlag, lostsign, roundmode,
               out_ready, flags_clr,
        input  in_ready, out_valid, result, of, nx, sticky_of, sticky_nx
    );

    modport slave (
        input  in_valid, sum, fullSum, nSigFlag, lostsign, roundmode,
               out_ready, flags_clr,
        output in_ready, out_valid, result, of, nx, sticky_of, sticky_nx
    );
endinterface

// File: rtl/fma16_round.sv
// fma16_round: two-stage IEEE half-precision rounding stage following the
// fma16 add/normalize stage.
//   clk     : clock
//   reset_n : asynchronous active-low reset, drops all in-flight ops
//   bus     : fma16_round_if.slave -- operand handshake in, result handshake
//             out, per-op of/nx, sticky_of/sticky_nx with flags_clr
// Stage 1 captures the operand and reduces fullSum to L/G/S bits.
// Stage 2 applies the rounding mode, saturates on overflow and registers
// the result. in_ready is combinational from out_ready (no skid buffer).
module fma16_round #(
    parameter int FW = 34
) (
    input logic          clk,
    input logic          reset_n,
    fma16_round_if.slave bus
);
    localparam int NF = 10;
    localparam int LB = FW - 1 - NF;   // position of the kept-fraction LSB

    typedef enum logic [1:0] {
        MODE_RZ  = 2'b00,
        MODE_RNE = 2'b01,
        MODE_RM  = 2'b10,
        MODE_RP  = 2'b11
    } rmode_e;

    // Handshake
    logic s1_adv, s2_adv;

    // Stage 1 registers
    logic        s1_valid_q;
    logic [15:0] s1_sum_q;
    rmode_e      s1_rm_q;
    logic        s1_ls_q;
    logic [1:0]  s1_nsig_q;
    logic        s1_l_q, s1_g_q, s1_s_q;
    logic        s1_l_d, s1_g_d, s1_s_d;

    // Stage 2 registers
    logic        s2_valid_q;
    logic [15:0] result_q, result_d;
    logic        of_q, of_d;
    logic        nx_q, nx_d;

    // Sticky flags
    logic        sticky_of_q, sticky_of_d;
    logic        sticky_nx_q, sticky_nx_d;

    // Upper significand bits are already represented by sum.
    logic unused_hi;
    assign unused_hi = ^bus.fullSum[FW-1:LB+1];

    assign s2_adv       = ~s2_valid_q | bus.out_ready;
    assign s1_adv       = ~s1_valid_q | s2_adv;
    assign bus.in_ready = s1_adv;

    // A dominated (discarded) term is nonzero but below the guard position.
    always_comb begin
        s1_l_d = bus.fullSum[LB];
        s1_g_d = bus.fullSum[LB-1];
        s1_s_d = |bus.fullSum[LB-2:0];
        if (bus.nSigFlag != 2'b00) begin
            s1_l_d = bus.sum[0];
            s1_g_d = 1'b0;
            s1_s_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_rm_q    <= MODE_RZ;
            s1_ls_q    <= 1'b0;
            s1_nsig_q  <= '0;
            s1_l_q     <= 1'b0;
            s1_g_q     <= 1'b0;
            s1_s_q     <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sum_q  <= bus.sum;
                s1_rm_q   <= rmode_e'(bus.roundmode);
                s1_ls_q   <= bus.lostsign;
                s1_nsig_q <= bus.nSigFlag;
                s1_l_q    <= s1_l_d;
                s1_g_q    <= s1_g_d;
                s1_s_q    <= s1_s_d;
            end
        end
    end

    // Stage 2 rounding
    logic        sgn, away, rnd_base, rnd, dec, ovf;
    logic [14:0] mag, mag_rnd;

    always_comb begin
        sgn  = s1_sum_q[15];
        mag  = s1_sum_q[14:0];
        // mode rounds away from zero for this sign (toward its infinity)
        away = ((s1_rm_q == MODE_RP) & ~sgn) | ((s1_rm_q == MODE_RM) & sgn);

        case (s1_rm_q)
            MODE_RNE: rnd_base = s1_g_q & (s1_l_q | s1_s_q);
            MODE_RZ:  rnd_base = 1'b0;
            default:  rnd_base = away & (s1_g_q | s1_s_q);
        endcase

        rnd = rnd_base;
        dec = 1'b0;
        // An opposite-sign discarded term pulls the true magnitude just
        // below sum; modes that round toward zero then step down one ulp.
        if (s1_nsig_q != 2'b00 && s1_ls_q != sgn) begin
            rnd = 1'b0;
            dec = (s1_rm_q != MODE_RNE) & ~away;
        end

        mag_rnd = mag;
        if (rnd)
            mag_rnd = mag + 15'd1;
        else if (dec && mag != '0)
            mag_rnd = mag - 15'd1;

        ovf = (mag_rnd[14:10] == 5'h1f) | (mag[14:10] == 5'h1f);

        if (ovf) begin
            result_d = {sgn, ((s1_rm_q == MODE_RNE) | away) ? 15'h7C00 : 15'h7BFF};
            of_d     = 1'b1;
            nx_d     = 1'b1;
        end else begin
            result_d = {sgn, mag_rnd};
            of_d     = 1'b0;
            nx_d     = s1_g_q | s1_s_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            of_q       <= 1'b0;
            nx_q       <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                result_q <= result_d;
                of_q     <= of_d;
                nx_q     <= nx_d;
            end
        end
    end

    // A transfer coinciding with a clear leaves exactly that op's flags.
    always_comb begin
        sticky_of_d = sticky_of_q;
        sticky_nx_d = sticky_nx_q;
        if (s2_valid_q && bus.out_ready) begin
            sticky_of_d = (bus.flags_clr ? 1'b0 : sticky_of_q) | of_q;
            sticky_nx_d = (bus.flags_clr ? 1'b0 : sticky_nx_q) | nx_q;
        end else if (bus.flags_clr) begin
            sticky_of_d = 1'b0;
            sticky_nx_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sticky_of_q <= 1'b0;
            sticky_nx_q <= 1'b0;
        end else begin
            sticky_of_q <= sticky_of_d;
            sticky_nx_q <= sticky_nx_d;
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.result    = result_q;
    assign bus.of        = of_q;
    assign bus.nx        = nx_q;
    assign bus.sticky_of = sticky_of_q;
    assign bus.sticky_nx = sticky_nx_q;
endmodule

// File: tb/tb_fma16_round.sv
// tb_fma16_round: directed and randomized checks of fma16_round against a
// value-level rounding model and an in-order expectation queue.
module tb_fma16_round;
    typedef struct {
        logic [15:0] res;
        logic        of;
        logic        nx;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fma16_round_if #(.FW(34)) bus ();

    fma16_round #(.FW(34)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   bp_t = 0;
    bit   strict_lat = 1'b0;
    logic st_of = 1'b0;
    logic st_nx = 1'b0;
    exp_t q[$];

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkint(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Value-level rounding: magnitude m plus a fraction r/2^23 of an ulp
    // (or an infinitesimal of known sign when a term was dominated).
    function automatic exp_t model(input logic [15:0] sm, input logic [33:0] fs,
                                   input logic [1:0] ns, input logic ls,
                                   input logic [1:0] rm);
        exp_t e;
        int   m, m2, r, half;
        bit   s, away, inexact, ovf;
        s    = sm[15];
        m    = int'(sm[14:0]);
        r    = int'(fs[22:0]);
        half = 1 << 22;
        away = (rm == 2'b11 && !s) || (rm == 2'b10 && s);
        if (ns == 2'b00) begin
            inexact = (r != 0);
            if (rm == 2'b00)      m2 = m;
            else if (rm == 2'b01) m2 = (r > half || (r == half && (m % 2) == 1)) ? m + 1 : m;
            else                  m2 = (away && r != 0) ? m + 1 : m;
        end else begin
            inexact = 1'b1;
            if (ls == s)                      m2 = away ? m + 1 : m;
            else if (rm != 2'b01 && !away)    m2 = (m > 0) ? m - 1 : 0;
            else                              m2 = m;
        end
        ovf = (m2 >= 31 * 1024) || (sm[14:10] == 5'd31);
        if (ovf) begin
            e.res = {s, (rm == 2'b01 || away) ? 15'h7C00 : 15'h7BFF};
            e.of  = 1'b1;
            e.nx  = 1'b1;
        end else begin
            e.res = {s, 15'(m2)};
            e.of  = 1'b0;
            e.nx  = inexact;
        end
        e.acc = 0;
        return e;
    endfunction

    task automatic present(input logic [15:0] sm, input logic [33:0] fs,
                           input logic [1:0] ns, input logic ls, input logic [1:0] rm);
        bus.sum       = sm;
        bus.fullSum   = fs;
        bus.nSigFlag  = ns;
        bus.lostsign  = ls;
        bus.roundmode = rm;
    endtask

    // One clock cycle, entered and left just after a falling edge.
    task automatic tick(input logic iv, input logic ordy, input logic clr,
                        input exp_t e, output bit acc);
        exp_t e0, en;
        bus.in_valid  = iv;
        bus.out_ready = ordy;
        bus.flags_clr = clr;
        #1;
        chk1("in_ready", bus.in_ready, (q.size() < 2) || ordy);
        if (bus.out_valid && q.size() > 0)
            chk16("result", bus.result, q[0].res);
        if (bus.out_valid && ordy) begin
            if (q.size() == 0) begin
                chk1("spurious_out", bus.out_valid, 1'b0);
            end else begin
                e0 = q.pop_front();
                chk1("of", bus.of, e0.of);
                chk1("nx", bus.nx, e0.nx);
                if (strict_lat) chkint("latency", cyc - e0.acc, 2);
                st_of = (clr ? 1'b0 : st_of) | e0.of;
                st_nx = (clr ? 1'b0 : st_nx) | e0.nx;
            end
        end else if (clr) begin
            st_of = 1'b0;
            st_nx = 1'b0;
        end
        acc = iv && bus.in_ready;
        if (acc) begin
            en = e;
            en.acc = cyc;
            q.push_back(en);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        chk1("sticky_of", bus.sticky_of, st_of);
        chk1("sticky_nx", bus.sticky_nx, st_nx);
    endtask

    task automatic idle(input logic ordy, input logic clr);
        exp_t d;
        bit   a;
        d.res = '0; d.of = 1'b0; d.nx = 1'b0; d.acc = 0;
        tick(1'b0, ordy, clr, d, a);
    endtask

    task automatic dop(input logic [15:0] sm, input logic [33:0] fs, input logic [1:0] ns,
                       input logic ls, input logic [1:0] rm,
                       input logic [15:0] res, input logic ofv, input logic nxv);
        exp_t e;
        bit   a;
        e.res = res; e.of = ofv; e.nx = nxv; e.acc = 0;
        present(sm, fs, ns, ls, rm);
        a = 1'b0;
        for (int i = 0; i < 8 && !a; i++) tick(1'b1, 1'b1, 1'b0, e, a);
        if (!a) chk1("accept_timeout", bus.in_ready, 1'b1);
    endtask

    task automatic rop(input bit bp);
        logic [31:0] rv;
        logic [15:0] sm;
        logic [22:0] lo;
        logic [33:0] fs;
        logic [1:0]  ns, rm;
        logic        ls, ordy, clr;
        exp_t        e;
        bit          a;
        rv = $urandom;
        sm = rv[15:0];
        case (rv[19:16])
            4'd0: sm = 16'h7BFF;
            4'd1: sm = 16'hFBFF;
            4'd2: sm = 16'h0000;
            4'd3: sm = 16'h8000;
            4'd4: sm = 16'h7C00;
            default: ;
        endcase
        lo = 23'($urandom);
        case ($urandom_range(0, 3))
            0: lo = '0;
            1: lo = 23'h400000;
            default: ;
        endcase
        fs = {1'b1, sm[9:0], lo};
        case ($urandom_range(0, 3))
            0: ns = 2'b01;
            1: ns = 2'b10;
            default: ns = 2'b00;
        endcase
        ls = 1'($urandom_range(0, 1));
        rm = 2'($urandom_range(0, 3));
        e  = model(sm, fs, ns, ls, rm);
        present(sm, fs, ns, ls, rm);
        a = 1'b0;
        for (int i = 0; i < 50 && !a; i++) begin
            if (bp) begin
                ordy = (bp_t >= 3);
                bp_t++;
                clr  = 1'b0;
            end else begin
                ordy = ($urandom_range(0, 3) != 0);
                clr  = ($urandom_range(0, 15) == 0);
            end
            tick(1'b1, ordy, clr, e, a);
        end
        if (!a) chk1("accept_timeout", bus.in_ready, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) idle(1'b1, 1'b0);
        chkint("drain_empty", q.size(), 0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.flags_clr = 1'b0;
        present(16'h0, 34'h0, 2'b00, 1'b0, 2'b00);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chk16("rst_result", bus.result, 16'h0000);
        chk1("rst_of", bus.of, 1'b0);
        chk1("rst_nx", bus.nx, 1'b0);
        chk1("rst_sticky_of", bus.sticky_of, 1'b0);
        chk1("rst_sticky_nx", bus.sticky_nx, 1'b0);
        chk1("rst_in_ready", bus.in_ready, 1'b1);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed rounding cases, back to back at full throughput
        strict_lat = 1'b1;
        dop(16'h3C00, 34'h200000001, 2'b00, 1'b0, 2'b01, 16'h3C00, 1'b0, 1'b1);
        dop(16'h3C00, 34'h200000001, 2'b00, 1'b0, 2'b11, 16'h3C01, 1'b0, 1'b1);
        dop(16'h3C00, 34'h200400000, 2'b00, 1'b0, 2'b01, 16'h3C00, 1'b0, 1'b1);
        dop(16'h3C01, 34'h200C00000, 2'b00, 1'b0, 2'b01, 16'h3C02, 1'b0, 1'b1);
        dop(16'h7BFF, 34'h3FFC00000, 2'b00, 1'b0, 2'b01, 16'h7C00, 1'b1, 1'b1);
        dop(16'h7BFF, 34'h3FFC00000, 2'b00, 1'b0, 2'b00, 16'h7BFF, 1'b0, 1'b1);
        dop(16'hFBFF, 34'h3FFC00000, 2'b00, 1'b0, 2'b11, 16'hFBFF, 1'b0, 1'b1);
        dop(16'hFBFF, 34'h3FFC00000, 2'b00, 1'b0, 2'b10, 16'hFC00, 1'b1, 1'b1);
        dop(16'h3C00, 34'h200000000, 2'b01, 1'b1, 2'b00, 16'h3BFF, 1'b0, 1'b1);
        dop(16'h3C00, 34'h200000000, 2'b01, 1'b0, 2'b11, 16'h3C01, 1'b0, 1'b1);
        dop(16'h3C00, 34'h200000000, 2'b01, 1'b1, 2'b01, 16'h3C00, 1'b0, 1'b1);
        dop(16'h3C00, 34'h200000000, 2'b10, 1'b1, 2'b10, 16'h3BFF, 1'b0, 1'b1);
        dop(16'hBC00, 34'h200000000, 2'b10, 1'b0, 2'b10, 16'hBC00, 1'b0, 1'b1);
        dop(16'hBC00, 34'h200000000, 2'b10, 1'b1, 2'b10, 16'hBC01, 1'b0, 1'b1);
        dop(16'h0000, 34'h200000000, 2'b01, 1'b1, 2'b00, 16'h0000, 1'b0, 1'b1);
        dop(16'h3C00, 34'h200000000, 2'b00, 1'b0, 2'b01, 16'h3C00, 1'b0, 1'b0);
        dop(16'h7C00, 34'h200000000, 2'b00, 1'b0, 2'b00, 16'h7BFF, 1'b1, 1'b1);
        drain();

        // Sticky: inexact then exact keeps sticky_nx
        idle(1'b1, 1'b1);
        dop(16'h3C00, 34'h200000001, 2'b00, 1'b0, 2'b01, 16'h3C00, 1'b0, 1'b1);
        dop(16'h3C00, 34'h200000000, 2'b00, 1'b0, 2'b01, 16'h3C00, 1'b0, 1'b0);
        drain();
        chk1("sticky_nx_kept", bus.sticky_nx, 1'b1);

        // Clear coinciding with an inexact transfer
        dop(16'h7BFF, 34'h3FFC00000, 2'b00, 1'b0, 2'b01, 16'h7C00, 1'b1, 1'b1);
        dop(16'h3C00, 34'h200000001, 2'b00, 1'b0, 2'b01, 16'h3C00, 1'b0, 1'b1);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b1);
        chk1("clr_xfer_nx", bus.sticky_nx, 1'b1);
        chk1("clr_xfer_of", bus.sticky_of, 1'b0);
        strict_lat = 1'b0;

        // Backpressure: out_ready low for the first 3 cycles of a 4-op stream
        bp_t = 0;
        repeat (4) rop(1'b1);
        drain();

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 4) == 0) idle(1'($urandom_range(0, 1)), 1'b0);
            rop(1'b0);
        end
        drain();

        // Reset with both stages occupied
        repeat (2) rop(1'b1);
        reset_n = 1'b0;
        #1;
        chk1("midrst_out_valid", bus.out_valid, 1'b0);
        chk1("midrst_of", bus.of, 1'b0);
        chk1("midrst_nx", bus.nx, 1'b0);
        chk1("midrst_sticky_of", bus.sticky_of, 1'b0);
        chk1("midrst_sticky_nx", bus.sticky_nx, 1'b0);
        chk1("midrst_in_ready", bus.in_ready, 1'b1);
        q.delete();
        st_of = 1'b0;
        st_nx = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) idle(1'b1, 1'b0);
        chk1("postrst_out_valid", bus.out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
